// File: rtl/pcie_phy_pkg.sv
// Shared PCIe PHY definitions.
// FSM encodings and clock-generator defaults.
package pcie_phy_pkg;

  typedef enum logic [1:0] {
    ST_STOPPED  = 2'd0,
    ST_RUN      = 2'd1,
    ST_STOPPING = 2'd2
  } clkgen_state_e;

  localparam int CLKGEN_NUM_OUT    = 3;
  localparam int CLKGEN_BASE_SHIFT = 3;

endpackage

// File: rtl/clk_div_gen.sv
// Synchronous power-of-two clock divider bank.
// All flops on clk_32f; outputs come straight from registers.
module clk_div_gen
  import pcie_phy_pkg::*;
#(
  parameter int NUM_OUT    = CLKGEN_NUM_OUT,
  parameter int BASE_SHIFT = CLKGEN_BASE_SHIFT,
  localparam int CNT_W     = BASE_SHIFT + NUM_OUT - 1
) (
  input  logic               clk_32f,
  input  logic               reset,
  input  logic               en,
  input  logic               sync,
  output logic [NUM_OUT-1:0] clk_out,
  output logic [NUM_OUT-1:0] rise_stb,
  output logic               running,
  output logic               locked
);

  clkgen_state_e      state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               locked_q, locked_d;
  logic               running_q, running_d;
  logic [NUM_OUT-1:0] stb_q, stb_d;
  logic               cnt_max;

  assign cnt_max = (cnt_q == '1);

  // State, counter and registered outputs
  always_ff @(posedge clk_32f) begin
    if (!reset) begin
      state_q   <= ST_STOPPED;
      cnt_q     <= '0;
      locked_q  <= 1'b0;
      running_q <= 1'b0;
      stb_q     <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      locked_q  <= locked_d;
      running_q <= running_d;
      stb_q     <= stb_d;
    end
  end

  // Next state, counter and lock
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    locked_d = locked_q;
    unique case (state_q)
      ST_STOPPED: begin
        cnt_d = '0;
        if (en) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (sync) begin
          cnt_d    = '0;
          locked_d = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_max) locked_d = 1'b1;
        end
        if (!en) state_d = ST_STOPPING;
      end
      ST_STOPPING: begin
        if (sync) begin
          cnt_d   = '0;
          state_d = ST_STOPPED;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          if (en) state_d = ST_RUN;
          else if (cnt_max) state_d = ST_STOPPED;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = ST_STOPPED;
      end
    endcase
    if (state_d == ST_STOPPED) locked_d = 1'b0;
  end

  // Strobe on each output's rising bit, plus run flag
  always_comb begin
    stb_d     = cnt_d[CNT_W-1:BASE_SHIFT-1]
              & ~cnt_q[CNT_W-1:BASE_SHIFT-1];
    running_d = (state_d != ST_STOPPED);
  end

  assign clk_out  = cnt_q[CNT_W-1:BASE_SHIFT-1];
  assign rise_stb = stb_q;
  assign running  = running_q;
  assign locked   = locked_q;

endmodule

// File: tb/tb_clk_div_gen.sv
// Directed bench for clk_div_gen.
// Default, (1,1) and (5,2) instances share stimulus.
module tb_clk_div_gen;

  logic clk_32f = 1'b0;
  logic reset;
  logic en;
  logic sync;

  logic [2:0] d0_clk, d0_stb;
  logic       d0_run, d0_lock;
  logic [0:0] d1_clk, d1_stb;
  logic       d1_run, d1_lock;
  logic [4:0] d2_clk, d2_stb;
  logic       d2_run, d2_lock;

  int errors = 0;
  int checks = 0;

  always #5 clk_32f = ~clk_32f;

  clk_div_gen u_d0 (
    .clk_32f  (clk_32f),
    .reset    (reset),
    .en       (en),
    .sync     (sync),
    .clk_out  (d0_clk),
    .rise_stb (d0_stb),
    .running  (d0_run),
    .locked   (d0_lock)
  );

  clk_div_gen #(.NUM_OUT(1), .BASE_SHIFT(1)) u_d1 (
    .clk_32f  (clk_32f),
    .reset    (reset),
    .en       (en),
    .sync     (sync),
    .clk_out  (d1_clk),
    .rise_stb (d1_stb),
    .running  (d1_run),
    .locked   (d1_lock)
  );

  clk_div_gen #(.NUM_OUT(5), .BASE_SHIFT(2)) u_d2 (
    .clk_32f  (clk_32f),
    .reset    (reset),
    .en       (en),
    .sync     (sync),
    .clk_out  (d2_clk),
    .rise_stb (d2_stb),
    .running  (d2_run),
    .locked   (d2_lock)
  );

  task automatic edge1();
    @(posedge clk_32f);
    #1;
  endtask

  // Leaves every DUT just after its RUN-entry edge (edge 1, cnt=0)
  task automatic restart();
    reset = 1'b0;
    en    = 1'b1;
    sync  = 1'b0;
    edge1();
    reset = 1'b1;
    edge1();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    en    = 1'b1;
    sync  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      edge1();
      checks++;
      if ({d0_clk, d0_stb, d0_run, d0_lock} !== 8'h00) begin
        errors++;
        $display("FAIL reset_hold i=%0d got=%b exp=0", i,
                 {d0_clk, d0_stb, d0_run, d0_lock});
      end
    end
    reset = 1'b1;
    edge1();
    checks++;
    if ({d0_clk, d0_stb, d0_lock} !== 7'h00) begin
      errors++;
      $display("FAIL release_outs got=%b exp=0",
               {d0_clk, d0_stb, d0_lock});
    end
    checks++;
    if (d0_run !== 1'b1) begin
      errors++;
      $display("FAIL release_run got=%b exp=1", d0_run);
    end
  endtask

  task automatic test_periods();
    logic [4:0] cv, pv;
    int pulses = 0;
    for (int n = 2; n <= 66; n++) begin
      edge1();
      cv = 5'(n - 1);
      pv = 5'(n - 2);
      if (n <= 65 && d0_stb[2] === 1'b1) pulses++;
      checks++;
      if (d0_clk !== cv[4:2]) begin
        errors++;
        $display("FAIL period_clk n=%0d got=%b exp=%b",
                 n, d0_clk, cv[4:2]);
      end
      checks++;
      if (d0_stb !== (cv[4:2] & ~pv[4:2])) begin
        errors++;
        $display("FAIL period_stb n=%0d got=%b exp=%b",
                 n, d0_stb, cv[4:2] & ~pv[4:2]);
      end
    end
    checks++;
    if (pulses != 2) begin
      errors++;
      $display("FAIL stb2_count got=%0d exp=2", pulses);
    end
  endtask

  task automatic test_lock();
    logic exp_l;
    restart();
    for (int n = 1; n <= 40; n++) begin
      if (n > 1) edge1();
      exp_l = (n >= 33);
      checks++;
      if (d0_lock !== exp_l || d0_run !== 1'b1) begin
        errors++;
        $display("FAIL lock n=%0d got=%b/%b exp=%b/1",
                 n, d0_lock, d0_run, exp_l);
      end
    end
  endtask

  task automatic test_stop();
    logic [4:0] cv, pv;
    restart();
    repeat (5) edge1();
    en = 1'b0;
    for (int c = 6; c <= 31; c++) begin
      edge1();
      cv = 5'(c);
      pv = 5'(c - 1);
      checks++;
      if (d0_clk !== cv[4:2] || d0_run !== 1'b1 || d0_lock !== 1'b0
          || d0_stb !== (cv[4:2] & ~pv[4:2])) begin
        errors++;
        $display("FAIL stopping c=%0d clk=%b stb=%b run=%b lk=%b",
                 c, d0_clk, d0_stb, d0_run, d0_lock);
      end
    end
    for (int i = 0; i < 21; i++) begin
      edge1();
      checks++;
      if ({d0_clk, d0_stb, d0_run, d0_lock} !== 8'h00) begin
        errors++;
        $display("FAIL stopped i=%0d got=%b exp=0", i,
                 {d0_clk, d0_stb, d0_run, d0_lock});
      end
    end
  endtask

  task automatic test_stop_abort();
    logic [4:0] cv, pv;
    logic exp_l;
    restart();
    for (int n = 2; n <= 45; n++) begin
      en = !(n >= 12 && n < 16);
      edge1();
      cv = 5'(n - 1);
      pv = 5'(n - 2);
      exp_l = (n >= 33);
      checks++;
      if (d0_clk !== cv[4:2] || d0_stb !== (cv[4:2] & ~pv[4:2])
          || d0_lock !== exp_l || d0_run !== 1'b1) begin
        errors++;
        $display("FAIL abort n=%0d clk=%b stb=%b lk=%b run=%b",
                 n, d0_clk, d0_stb, d0_lock, d0_run);
      end
    end
    en = 1'b1;
  endtask

  task automatic test_sync();
    logic [4:0] cv;
    restart();
    repeat (51) edge1();
    checks++;
    if (d0_lock !== 1'b1) begin
      errors++;
      $display("FAIL sync_prelock got=%b exp=1", d0_lock);
    end
    sync = 1'b1;
    edge1();
    sync = 1'b0;
    checks++;
    if ({d0_clk, d0_stb, d0_lock} !== 7'h00 || d0_run !== 1'b1) begin
      errors++;
      $display("FAIL sync_run got=%b run=%b exp=0/1",
               {d0_clk, d0_stb, d0_lock}, d0_run);
    end
    for (int k = 1; k <= 32; k++) begin
      edge1();
      cv = 5'(k);
      checks++;
      if (d0_clk !== cv[4:2] || d0_lock !== (k == 32)) begin
        errors++;
        $display("FAIL relock k=%0d clk=%b lk=%b exp=%b/%b",
                 k, d0_clk, d0_lock, cv[4:2], k == 32);
      end
    end
    restart();
    repeat (5) edge1();
    en = 1'b0;
    repeat (2) edge1();
    checks++;
    if (d0_clk !== 3'b001 || d0_run !== 1'b1) begin
      errors++;
      $display("FAIL sync_pre_stop clk=%b run=%b exp=001/1",
               d0_clk, d0_run);
    end
    sync = 1'b1;
    edge1();
    sync = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (d0_clk !== 3'b000 || d0_run !== 1'b0) begin
        errors++;
        $display("FAIL sync_stop i=%0d clk=%b run=%b exp=000/0",
                 i, d0_clk, d0_run);
      end
      edge1();
    end
    sync = 1'b1;
    edge1();
    sync = 1'b0;
    checks++;
    if ({d0_clk, d0_run, d0_lock} !== 5'b0) begin
      errors++;
      $display("FAIL sync_idle got=%b exp=0", {d0_clk, d0_run, d0_lock});
    end
    en = 1'b1;
  endtask

  task automatic test_params();
    logic [0:0] c1, p1;
    logic [5:0] c2, p2;
    restart();
    for (int n = 1; n <= 70; n++) begin
      if (n > 1) edge1();
      c1 = 1'(n - 1);
      p1 = 1'(n - 2);
      c2 = 6'(n - 1);
      p2 = 6'(n - 2);
      checks++;
      if (d1_clk !== c1 || d1_stb !== (c1 & ~p1)
          || d1_lock !== (n >= 3) || d1_run !== 1'b1) begin
        errors++;
        $display("FAIL p11 n=%0d clk=%b stb=%b lk=%b run=%b",
                 n, d1_clk, d1_stb, d1_lock, d1_run);
      end
      checks++;
      if (d2_clk !== c2[5:1] || d2_stb !== (c2[5:1] & ~p2[5:1])
          || d2_lock !== (n >= 65) || d2_run !== 1'b1) begin
        errors++;
        $display("FAIL p52 n=%0d clk=%b stb=%b lk=%b run=%b",
                 n, d2_clk, d2_stb, d2_lock, d2_run);
      end
    end
    reset = 1'b0;
    edge1();
    checks++;
    if ({d0_clk, d0_stb, d0_run, d0_lock,
         d1_clk, d1_stb, d1_run, d1_lock,
         d2_clk, d2_stb, d2_run, d2_lock} !== 24'h0) begin
      errors++;
      $display("FAIL midrun_reset d0=%b d1=%b d2=%b exp=0",
               {d0_clk, d0_stb, d0_run, d0_lock},
               {d1_clk, d1_stb, d1_run, d1_lock},
               {d2_clk, d2_stb, d2_run, d2_lock});
    end
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0;
    en    = 1'b0;
    sync  = 1'b0;
    test_reset();
    test_periods();
    test_lock();
    test_stop();
    test_stop_abort();
    test_sync();
    test_params();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
